clk_divider_n: RTL and testbench
================================

// Module: clk_divider_n
// PURPOSE
//  Parametrised, runtime-programmable integer clock divider; next generation of the fixed /2 divider.
//  Divides clk by N (2..2^CNT_W-1) and produces a divided clock, a per-period tick and a cycle count.
//  Divisor changes take effect only at period boundaries, so they are glitch-free.
//  Sits between the system clock and downstream logic; instances cascade by feeding clk_o or tick.
// PARAMETERS
//  CNT_W        8   width of counter and divisor
//  DIV_DEFAULT  4   divisor after reset; must be 2..2^CNT_W-1
// PORTS
//  clk      in   1      system clock; all logic on rising edge, except the optional negedge flop
//  rst      in   1      synchronous, active-high reset
//  en       in   1      count enable; 0 = freeze counter and outputs
//  div_ld   in   1      load strobe for div_in
//  div_in   in   CNT_W  requested divisor N
//  cnt      out  CNT_W  phase counter, 0..N-1
//  clk_o    out  1      divided clock
//  tick     out  1      one-cycle pulse on the last cycle of each period
//  div_cur  out  CNT_W  divisor currently in force
//  div_pend out  1      a loaded divisor is waiting for the period boundary
//  div_err  out  1      one-cycle pulse: rejected load (div_in < 2)
// BEHAVIOUR
//  Reset values: cnt=DIV_DEFAULT-1, clk_o=0, tick=0, div_cur=DIV_DEFAULT, div_pend=0, div_err=0, pending reg=0.
//  Counting (en=1): cnt increments by 1. At cnt==div_cur-1 it wraps to 0, and that wrap is the period boundary.
//  The first enabled edge after reset wraps cnt to 0.
//  clk_o is registered and equals (cnt < div_cur>>1) for the cnt value in the same cycle.
//   N=4 gives 1100. N=5 gives 11000.
//  tick = en & ~rst & (cnt==div_cur-1); combinational from registered state.
//  Hold (en=0): cnt, clk_o and div_cur hold; tick=0.
//  Load with div_in>=2:
//   - en=1, no wrap this edge: value stored as pending and div_pend=1 from the next cycle.
//     The value is applied at the next wrap edge: div_cur updates, cnt=0, div_pend clears.
//   - en=1 on the wrap edge: applied on that same edge; the new period starts with the new N.
//   - en=0: applied on the next edge. cnt=new N-1, clk_o=0 (same state as after reset).
//   - Another load while pending: the last write wins; still a single apply at the boundary.
//  Load with div_in<2: ignored. div_err=1 for exactly the next cycle. Any existing pending value is kept.
//  div_ld and rst in the same cycle: rst wins and the load is discarded.
//  rst mid-period: next cycle holds the reset values. Any pending divisor is lost.
//  Arithmetic: unsigned, CNT_W-bit. div_cur-1 never underflows because div_cur>=2 always.
// CONFIGURATION
//  DIV_ODD_DUTY50_EN defined:
//   - One negedge flop samples the registered clk_o.
//   - Port clk_o = clk_o_r | (div_cur[0] & clk_o_neg).
//   - Odd N gets high time N/2 clk periods, e.g. N=5 high 2.5 / low 2.5. Even N is unchanged.
//   - The negedge flop clears whenever rst is sampled high.
//  Undefined: no negedge logic; odd N has high time floor(N/2) and low time ceil(N/2).
//  tick, cnt and the handshake are identical in both builds.
// TESTING
//  T1 rst 2 cycles, en=1, default N=4:
//   -> cnt 0,1,2,3,0..; clk_o 1,1,0,0 repeating; tick high only at cnt=3.
//  T2 div_ld=1, div_in=5 at cnt=1 (N=4):
//   -> div_pend=1 for 2 cycles; old period ends at cnt=3; then cnt 0..4, clk_o 1,1,0,0,0, div_cur=5.
//   -> With DIV_ODD_DUTY50_EN, clk_o high for 2.5 clk periods.
//  T3 div_ld=1, div_in=1:
//   -> div_err=1 for one cycle; div_cur stays 4; period pattern unchanged.
//  T4 en=0 for 3 cycles at cnt=2:
//   -> cnt=2, clk_o=0, tick=0 held; counting resumes at cnt=3 and tick fires.
//  T5 div_ld, div_in=6 on the wrap cycle (cnt=3), then div_in=7, div_in=3 before the next wrap:
//   -> 6 applies immediately; next period uses 3; 7 never takes effect.
//  T6 rst at cnt=2 with div_cur=6 and a pending load of 9:
//   -> next cycle cnt=3, clk_o=0, div_cur=4, div_pend=0; normal N=4 sequence follows.

Source files
------------

// File: rtl/clk_divider_n.sv
// -----------------------------------------------------------------------------
// clk_divider_n
//
// Runtime-programmable integer clock divider. Divides clk by N, where N lies
// in 2..2^CNT_W-1. It produces a registered divided clock, a one-cycle tick on
// the last cycle of each period, and the phase counter. A new divisor is taken
// up only at a period boundary, so clk_o never glitches. The exception is a
// load while the counter is frozen, which restarts the divider from a clean
// state.
//
// Parameters
//   CNT_W        width of the phase counter and the divisor
//   DIV_DEFAULT  divisor after reset (2..2^CNT_W-1)
//
// Ports
//   clk       in   system clock; all state changes on the rising edge
//   rst       in   synchronous, active-high reset
//   en        in   count enable; 0 freezes the counter and the outputs
//   div_ld    in   load strobe for div_in
//   div_in    in   requested divisor N
//   cnt       out  phase counter, 0..N-1
//   clk_o     out  divided clock, high for cnt < N/2
//   tick      out  high on the last cycle of each period while enabled
//   div_cur   out  divisor currently in force
//   div_pend  out  a loaded divisor is waiting for the period boundary
//   div_err   out  one-cycle pulse after a rejected load (div_in < 2)
//
// Build option
//   DIV_ODD_DUTY50_EN  adds one falling-edge flop that stretches clk_o by
//                      half a clk period for odd N, giving a 50% duty cycle.
//                      Without it, odd N is high for floor(N/2) cycles and
//                      low for ceil(N/2) cycles.
// -----------------------------------------------------------------------------
module clk_divider_n #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_in,
  output logic [CNT_W-1:0] cnt,
  output logic             clk_o,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             div_pend,
  output logic             div_err
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DIV_DEFAULT - 1);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_o_q, clk_o_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_err_q, div_err_d;

  logic [CNT_W-1:0] cnt_last;
  logic             wrap;
  logic             ld_ok;

  // div_cur_q is never below 2, so this subtraction cannot underflow.
  assign cnt_last = div_cur_q - ONE;
  assign wrap     = (cnt_q == cnt_last);
  assign ld_ok    = div_ld && (div_in >= DIV_MIN);

  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that
    // leaves a combinational output unassigned would infer a latch.
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_vld_d = pend_vld_q;
    div_err_d  = div_ld && !ld_ok;

    if (!en) begin
      // A load while frozen takes effect immediately and restarts the
      // divider as if from reset. No period is running, so clk_o cannot
      // glitch mid-period.
      if (ld_ok) begin
        div_cur_d  = div_in;
        cnt_d      = div_in - ONE;
        pend_vld_d = 1'b0;
      end
    end else if (wrap) begin
      // Period boundary: a load arriving on this edge beats a stored pending
      // value, because it is the most recent write.
      cnt_d      = '0;
      pend_vld_d = 1'b0;
      if (ld_ok) begin
        div_cur_d = div_in;
      end else if (pend_vld_q) begin
        div_cur_d = pend_val_q;
      end
    end else begin
      cnt_d = cnt_q + ONE;
      if (ld_ok) begin
        pend_val_d = div_in;
        pend_vld_d = 1'b1;
      end
    end

    // clk_o is registered and follows the counter value it sits alongside.
    // This keeps the reset state (cnt = N-1, clk_o = 0) self-consistent.
    clk_o_d = (cnt_d < (div_cur_d >> 1));
  end

  // NOTE: the reset here is synchronous. It is sampled on the rising edge
  // like any other input, so a reset in the same cycle as a load discards
  // that load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop sees the values from before the edge.
    if (rst) begin
      cnt_q      <= CNT_RST;
      clk_o_q    <= 1'b0;
      div_cur_q  <= DIV_RST;
      pend_val_q <= '0;
      pend_vld_q <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk_o_q    <= clk_o_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_vld_q <= pend_vld_d;
      div_err_q  <= div_err_d;
    end
  end

`ifdef DIV_ODD_DUTY50_EN
  // The falling-edge copy of clk_o extends each high phase by half a clk
  // period. It is used only when N is odd, so even N keeps its exact
  // 50% duty cycle.
  logic clk_o_neg_q, clk_o_neg_d;

  assign clk_o_neg_d = rst ? 1'b0 : clk_o_q;

  always_ff @(negedge clk) begin
    clk_o_neg_q <= clk_o_neg_d;
  end

  assign clk_o = clk_o_q | (div_cur_q[0] & clk_o_neg_q);
`else
  assign clk_o = clk_o_q;
`endif

  assign cnt      = cnt_q;
  assign tick     = en & ~rst & wrap;
  assign div_cur  = div_cur_q;
  assign div_pend = pend_vld_q;
  assign div_err  = div_err_q;

endmodule

// File: tb/tb_clk_divider_n.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_n
//
// Self-checking bench for clk_divider_n (CNT_W=8, DIV_DEFAULT=4). A behavioural
// model advances once per cycle as stimulus is driven. Its predicted register
// state is pushed to a scoreboard queue and compared after the next rising
// edge. tick and clk_o are compared against the model in the middle of the
// low phase. Directed scenarios cover the documented cases, followed by a
// short random run.
// -----------------------------------------------------------------------------
module tb_clk_divider_n;

  localparam int CNT_W       = 8;
  localparam int DIV_DEFAULT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_ld;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] cnt;
  logic             clk_o;
  logic             tick;
  logic [CNT_W-1:0] div_cur;
  logic             div_pend;
  logic             div_err;

  clk_divider_n #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_ld  (div_ld),
    .div_in  (div_in),
    .cnt     (cnt),
    .clk_o   (clk_o),
    .tick    (tick),
    .div_cur (div_cur),
    .div_pend(div_pend),
    .div_err (div_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int div;
    int pend;
    int err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_cnt, m_clk, m_div, m_pval, m_pend, m_err;
  int m_neg      = 0;
  int m_rst_prev = 1;
  bit m_valid    = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_next(input int r, input int e, input int l, input int d);
    bit ok;
    int nd;
    ok = (l != 0) && (d >= 2);
    if (r != 0) begin
      m_cnt  = DIV_DEFAULT - 1;
      m_clk  = 0;
      m_div  = DIV_DEFAULT;
      m_pval = 0;
      m_pend = 0;
      m_err  = 0;
      m_valid = 1'b1;
      return;
    end
    m_err = (l != 0 && !ok) ? 1 : 0;
    if (e == 0) begin
      if (ok) begin
        m_div  = d;
        m_cnt  = d - 1;
        m_clk  = 0;
        m_pend = 0;
      end
    end else if (m_cnt == m_div - 1) begin
      nd = ok ? d : (m_pend != 0 ? m_pval : m_div);
      m_div  = nd;
      m_cnt  = 0;
      m_clk  = 1;   // count 0 is always in the high half since N >= 2
      m_pend = 0;
    end else begin
      m_cnt = m_cnt + 1;
      m_clk = (m_cnt < m_div / 2) ? 1 : 0;
      if (ok) begin
        m_pval = d;
        m_pend = 1;
      end
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // combinational outputs, then compare registered state after the rising edge.
  task automatic drive(input int r, input int e, input int l, input int d);
    exp_t x;
    @(negedge clk);
    m_neg = (m_rst_prev != 0) ? 0 : m_clk;
    #2;
    rst    = r[0];
    en     = e[0];
    div_ld = l[0];
    div_in = CNT_W'(d);
    #1;
    if (m_valid) begin
      check("tick", int'(tick), (e != 0 && r == 0 && m_cnt == m_div - 1) ? 1 : 0);
`ifdef DIV_ODD_DUTY50_EN
      check("clk_o", int'(clk_o), m_clk | ((m_div % 2) & m_neg));
`else
      check("clk_o", int'(clk_o), m_clk);
`endif
    end
    model_next(r, e, l, d);
    m_rst_prev = r;
    x = '{m_cnt, m_div, m_pend, m_err};
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("cnt", int'(cnt), x.cnt);
    check("div_cur", int'(div_cur), x.div);
    check("div_pend", int'(div_pend), x.pend);
    check("div_err", int'(div_err), x.err);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0);
  endtask

  // Count forward until the model sits at phase v, with a bounded budget.
  task automatic run_to(input int v);
    int k;
    k = 0;
    while (m_cnt != v && k < 100) begin
      drive(0, 1, 0, 0);
      k++;
    end
    if (k >= 100) check("run_to_timeout", m_cnt, v);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    div_ld = 1'b0;
    div_in = '0;

    // T1: reset for two cycles, then the default N=4 pattern
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    check("t1_rst_cnt", int'(cnt), 3);
    check("t1_rst_div", int'(div_cur), 4);
    check("t1_rst_clk", int'(clk_o), 0);
    run(9);

    // T3: rejected load keeps N=4
    drive(0, 1, 1, 1);
    check("t3_err", int'(div_err), 1);
    run(8);
    check("t3_div", int'(div_cur), 4);

    // T4: freeze at cnt=2 for three cycles, then resume
    run_to(2);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("t4_hold_cnt", int'(cnt), 2);
    run(6);

    // T2: load 5 at cnt=1, applied at the next wrap
    run_to(1);
    drive(0, 1, 1, 5);
    check("t2_pend", int'(div_pend), 1);
    run(12);
    check("t2_div", int'(div_cur), 5);

    // T5: load on the wrap edge applies at once, and the last write wins
    drive(1, 1, 0, 0);
    run_to(3);
    drive(0, 1, 1, 6);
    check("t5_div6", int'(div_cur), 6);
    run_to(1);
    drive(0, 1, 1, 7);
    drive(0, 1, 1, 3);
    run(10);
    check("t5_div3", int'(div_cur), 3);

    // T6: reset mid-period discards the pending divisor
    drive(1, 1, 0, 0);
    run_to(3);
    drive(0, 1, 1, 6);
    run_to(1);
    drive(0, 1, 1, 9);
    drive(1, 1, 0, 0);
    check("t6_cnt", int'(cnt), 3);
    check("t6_div", int'(div_cur), 4);
    check("t6_pend", int'(div_pend), 0);
    run(8);

    // Reset and load in the same cycle: reset wins
    drive(1, 1, 1, 7);
    check("rst_ld_div", int'(div_cur), 4);

    // Load while frozen restarts with the new N
    drive(0, 0, 1, 7);
    check("frozen_ld_cnt", int'(cnt), 6);
    run(10);

    // Rejected load while a value is pending keeps that value
    run_to(1);
    drive(0, 1, 1, 9);
    drive(0, 1, 1, 0);
    check("err_keep_pend", int'(div_pend), 1);
    run(14);
    check("err_keep_div", int'(div_cur), 9);

    // Random mix
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0) ? 1 : 0,
            ($urandom_range(0, 7) != 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            int'($urandom_range(0, 12)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
